// File: rtl/fetch_if.sv
// Instruction-fetch bundle: bus request/response toward memory, instruction
// handshake toward decode, and the redirect input from the branch unit.
interface fetch_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_ok;
    logic [31:0] iresp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_ok, iresp_data,
        output instr_valid, instr, pc,
        input  instr_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_ok, iresp_data,
        input  instr_valid, instr, pc,
        output instr_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word requests, a DEPTH-entry instruction
// FIFO toward decode, and redirect handling that drops in-flight responses.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic   clk,
    input  logic   reset,
    fetch_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_KILL, S_STALL} state_t;

    state_t           state;
    logic [63:0]      pc_reg;
    logic [63:0]      kill_addr;
    logic [63:0]      addr_hold;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [31:0]      mem_instr [DEPTH];
    logic [63:0]      mem_pc    [DEPTH];

    logic        redirect;
    logic [63:0] redir_pc;
    logic        push;
    logic        pop;
    logic [63:0] ireq_addr_c;

    assign redirect = bus.redirect_valid;
    assign redir_pc = bus.redirect_pc & ~64'h3;
    assign push     = (state == S_REQ) && !redirect && bus.iresp_ok;
    assign pop      = (count != '0) && bus.instr_ready && !redirect;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_W'(1);
        else if (pop && !push)
            count_next = count - CNT_W'(1);
    end

    // The address must stay put while a request is outstanding, so outside
    // S_REQ/S_KILL it simply repeats whatever was last presented.
    always_comb begin
        ireq_addr_c = addr_hold;
        case (state)
            S_REQ:   ireq_addr_c = pc_reg;
            S_KILL:  ireq_addr_c = kill_addr;
            default: ireq_addr_c = addr_hold;
        endcase
    end

    assign bus.ireq_valid  = (state == S_REQ) || (state == S_KILL);
    assign bus.ireq_addr   = ireq_addr_c;
    assign bus.instr_valid = (count != '0);
    // Gate the head with valid so stale or uninitialised entries never escape.
    assign bus.instr       = bus.instr_valid ? mem_instr[head] : 32'h0;
    assign bus.pc          = bus.instr_valid ? mem_pc[head]    : 64'h0;

    // FIFO storage: data only, no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[tail] <= bus.iresp_data;
            mem_pc[tail]    <= pc_reg;
        end
    end

    // Control: fetch FSM, pointers and fetch PC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            pc_reg    <= RESET_PC;
            kill_addr <= 64'h0;
            addr_hold <= 64'h0;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
        end else begin
            addr_hold <= ireq_addr_c;

            if (redirect) begin
                count  <= '0;
                head   <= '0;
                tail   <= '0;
                pc_reg <= redir_pc;
            end else begin
                count <= count_next;
                if (pop)
                    head <= head + PTR_W'(1);
                if (push) begin
                    tail   <= tail + PTR_W'(1);
                    pc_reg <= pc_reg + 64'd4;
                end
            end

            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (redirect) begin
                        // No bus cancel: the old request must still complete.
                        if (!bus.iresp_ok) begin
                            kill_addr <= pc_reg;
                            state     <= S_KILL;
                        end
                    end else if (bus.iresp_ok) begin
                        state <= (count_next == CNT_W'(DEPTH)) ? S_STALL : S_REQ;
                    end
                end
                S_KILL: begin
                    if (bus.iresp_ok)
                        state <= S_REQ;
                end
                S_STALL: begin
                    if (redirect || pop)
                        state <= S_REQ;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, backpressure, redirects,
// asynchronous reset and address wrap, with hand-computed expectations.
module tb_fetch_unit;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    fetch_if bus ();

    fetch_unit #(
        .RESET_PC (64'h0000_0000_8000_0000),
        .DEPTH    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b0;
        bus.iresp_ok       = 1'b0;
        bus.iresp_data     = 32'h0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;

        // Reset state
        #3;
        chk("rst_ireq_valid",  bus.ireq_valid, 0);
        chk("rst_ireq_addr",   bus.ireq_addr, 0);
        chk("rst_instr_valid", bus.instr_valid, 0);
        chk("rst_instr",       bus.instr, 0);
        chk("rst_pc",          bus.pc, 0);

        // Sequential fetch with a 1-cycle bus and decode always ready
        #9 reset = 1'b1;
        step();
        chk("seq_req0_valid", bus.ireq_valid, 1);
        chk("seq_req0_addr",  bus.ireq_addr, 64'h8000_0000);
        chk("seq_empty",      bus.instr_valid, 0);
        bus.iresp_ok = 1'b1; bus.iresp_data = 32'h1111_0000; bus.instr_ready = 1'b1;
        step();
        chk("seq_w0_valid", bus.instr_valid, 1);
        chk("seq_w0_instr", bus.instr, 32'h1111_0000);
        chk("seq_w0_pc",    bus.pc, 64'h8000_0000);
        chk("seq_req1_addr", bus.ireq_addr, 64'h8000_0004);
        bus.iresp_data = 32'h1111_0001;
        step();
        chk("seq_w1_instr", bus.instr, 32'h1111_0001);
        chk("seq_w1_pc",    bus.pc, 64'h8000_0004);
        chk("seq_req2_addr", bus.ireq_addr, 64'h8000_0008);
        bus.iresp_data = 32'h1111_0002;
        step();
        chk("seq_w2_instr", bus.instr, 32'h1111_0002);
        chk("seq_w2_pc",    bus.pc, 64'h8000_0008);
        bus.iresp_ok = 1'b0;
        step();
        chk("seq_drained", bus.instr_valid, 0);

        // Backpressure: FIFO fills, request stops, resumes after one pop
        reset_dut();
        bus.instr_ready = 1'b0; bus.iresp_ok = 1'b1; bus.iresp_data = 32'h2222_0000;
        step();
        chk("bp_w0_instr", bus.instr, 32'h2222_0000);
        chk("bp_w0_pc",    bus.pc, 64'h8000_0000);
        bus.iresp_data = 32'h2222_0001;
        step();
        chk("bp_full_ireq_valid", bus.ireq_valid, 0);
        chk("bp_full_head",       bus.instr, 32'h2222_0000);
        chk("bp_full_addr_held",  bus.ireq_addr, 64'h8000_0004);
        step();
        chk("bp_stall_ireq_valid", bus.ireq_valid, 0);
        bus.instr_ready = 1'b1;
        step();
        chk("bp_resume_valid", bus.ireq_valid, 1);
        chk("bp_resume_addr",  bus.ireq_addr, 64'h8000_0008);
        chk("bp_w1_instr",     bus.instr, 32'h2222_0001);
        chk("bp_w1_pc",        bus.pc, 64'h8000_0004);
        bus.iresp_ok = 1'b0;
        step();
        chk("bp_drained", bus.instr_valid, 0);

        // Redirect while a request is pending with no response
        reset_dut();
        bus.instr_ready = 1'b0; bus.iresp_ok = 1'b1; bus.iresp_data = 32'h3333_0000;
        step();
        bus.iresp_ok = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_1000;
        step();
        chk("kill_addr_stable0", bus.ireq_addr, 64'h8000_0004);
        chk("kill_ireq_valid",   bus.ireq_valid, 1);
        chk("kill_flushed",      bus.instr_valid, 0);
        bus.redirect_valid = 1'b0;
        step();
        chk("kill_addr_stable1", bus.ireq_addr, 64'h8000_0004);
        bus.iresp_ok = 1'b1; bus.iresp_data = 32'hDEAD_BEEF;
        step();
        chk("kill_dropped",  bus.instr_valid, 0);
        chk("kill_new_addr", bus.ireq_addr, 64'h8000_1000);
        bus.iresp_data = 32'h3333_0005;
        step();
        chk("kill_w_instr", bus.instr, 32'h3333_0005);
        chk("kill_w_pc",    bus.pc, 64'h8000_1000);

        // Redirect coincident with a response and an attempted pop
        bus.iresp_data = 32'hBAD0_BAD0; bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_2002;
        step();
        chk("coin_flushed",  bus.instr_valid, 0);
        chk("coin_addr",     bus.ireq_addr, 64'h8000_2000);
        chk("coin_req_valid", bus.ireq_valid, 1);
        bus.redirect_valid = 1'b0; bus.instr_ready = 1'b0; bus.iresp_data = 32'h4444_0006;
        step();
        chk("coin_w_instr", bus.instr, 32'h4444_0006);
        chk("coin_w_pc",    bus.pc, 64'h8000_2000);
        bus.iresp_ok = 1'b0;

        // Asynchronous reset between edges while requesting with one entry held
        #3 reset = 1'b0;
        #1;
        chk("arst_ireq_valid",  bus.ireq_valid, 0);
        chk("arst_instr_valid", bus.instr_valid, 0);
        chk("arst_instr",       bus.instr, 0);
        chk("arst_pc",          bus.pc, 0);
        step();
        reset = 1'b1;
        step();
        chk("arst_restart_valid", bus.ireq_valid, 1);
        chk("arst_restart_addr",  bus.ireq_addr, 64'h8000_0000);

        // Address wrap at the top of the 64-bit space
        bus.iresp_ok = 1'b1; bus.iresp_data = 32'h5555_0000;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        chk("wrap_req0_addr", bus.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        bus.redirect_valid = 1'b0; bus.instr_ready = 1'b1; bus.iresp_data = 32'h5555_0007;
        step();
        chk("wrap_req1_addr", bus.ireq_addr, 64'h0);
        chk("wrap_w0_pc",     bus.pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_w0_instr",  bus.instr, 32'h5555_0007);
        bus.iresp_data = 32'h5555_0008;
        step();
        chk("wrap_w1_pc",    bus.pc, 64'h0);
        chk("wrap_w1_instr", bus.instr, 32'h5555_0008);
        chk("wrap_req2_addr", bus.ireq_addr, 64'h4);
        bus.iresp_ok = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
